if_fetch_queue: RTL and testbench

//   Parametrised instruction-fetch stage with a decoupled fetch queue.

---
 rtl/if_fetch_queue.sv | 137 +++++++++++++
 tb/tb_if_fetch_queue.sv | 551 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: sequential fetch into a DEPTH-entry queue with redirect flush.
// Define IF_PERF_CNT_EN to add the perf_fetched/perf_flushed counters.
module if_fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_offset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] pcQ [DEPTH];
  logic [XLEN-1:0] instrQ [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0] allocPtr;
  logic [PW-1:0] fillPtr;
  logic [PW-1:0] headPtr;
  logic [CW-1:0] occ;
  logic [CW-1:0] pend;
  logic [CW-1:0] dropCnt;

  logic [CW:0] credit;
  logic reqOk;
  logic issue;
  logic headValid;
  logic pop;
  logic fill;
  logic rspDrop;
  logic rspCons;
  logic [XLEN-1:0] target;

  // occ + dropCnt bounds entries plus stale responses still owed
  assign credit = {1'b0, occ} + {1'b0, dropCnt};
  assign reqOk = !rst && !br_taken && (credit < CREDITS);
  assign issue = reqOk && mem_req_ready;

  assign mem_req_valid = reqOk;
  assign mem_req_addr = fetchPc;

  assign headValid = (occ != '0) && filled[headPtr];
  assign pop = headValid && out_ready;
  assign out_valid = headValid;
  assign out_pc = headValid ? pcQ[headPtr] : '0;
  assign out_instr = headValid ? instrQ[headPtr] : '0;

  assign rspDrop = mem_rsp_valid && (dropCnt != '0);
  assign rspCons = mem_rsp_valid && ((dropCnt != '0) || (pend != '0));
  assign fill = mem_rsp_valid && (dropCnt == '0) && (pend != '0) && !br_taken;

  assign target = br_pc + (br_offset << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc <= RESET_PC;
      filled <= '0;
      allocPtr <= '0;
      fillPtr <= '0;
      headPtr <= '0;
      occ <= '0;
      pend <= '0;
      dropCnt <= '0;
    end else if (br_taken) begin
      fetchPc <= target;
      filled <= '0;
      allocPtr <= '0;
      fillPtr <= '0;
      headPtr <= '0;
      occ <= '0;
      pend <= '0;
      // every still-unanswered request becomes a response to discard
      dropCnt <= dropCnt + pend - CW'(rspCons);
    end else begin
      if (issue) begin
        fetchPc <= fetchPc + XLEN'(4);
        allocPtr <= allocPtr + PW'(1);
        filled[allocPtr] <= 1'b0;
      end
      if (fill) begin
        filled[fillPtr] <= 1'b1;
        fillPtr <= fillPtr + PW'(1);
      end
      if (pop) headPtr <= headPtr + PW'(1);
      if (rspDrop) dropCnt <= dropCnt - CW'(1);
      occ <= occ + CW'(issue) - CW'(pop);
      pend <= pend + CW'(issue) - CW'(fill);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pcQ[allocPtr] <= fetchPc;
    if (fill) instrQ[fillPtr] <= mem_rsp_data;
  end

`ifdef IF_PERF_CNT_EN
  logic [CW-1:0] flushEnt;
  logic rspGone;
  logic [32:0] flushSum;

  assign flushEnt = br_taken ? (occ - CW'(pop)) : '0;
  assign rspGone = mem_rsp_valid &&
                   ((dropCnt != '0) || (br_taken && (pend != '0)));
  assign flushSum = {1'b0, perf_flushed} + 33'(flushEnt) + 33'(rspGone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      perf_flushed <= flushSum[32] ? '1 : flushSum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: scenario tasks plus randomized run against a
// queue-based memory/scoreboard model of the fetch stage.
module tb_if_fetch_queue;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic br_taken;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic mem_req_valid;
  logic mem_req_ready;
  logic [31:0] mem_req_addr;
  logic mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  if_fetch_queue #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .br_taken(br_taken),
    .br_pc(br_pc),
    .br_offset(br_offset),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int ep;
    int rdy;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit full;
  } ent_t;

  mreq_t mq[$];
  ent_t eq[$];
  int cyc = 0;
  int epoch = 0;
  int lastRdy = 0;
  int errs = 0;
  int checks = 0;
  logic [31:0] nextPc = 32'h0;

  bit brDrv = 1'b0;
  bit ordy = 1'b0;
  logic [31:0] bpc = '0;
  logic [31:0] boff = '0;
  int rdyPct = 100;
  int latMin = 1;
  int latMax = 1;

  bit eReqV;
  bit eOutV;
  logic [31:0] eOutPc;
  logic [31:0] eOutInstr;

  // drive this cycle's inputs and derive what the stage must show
  task automatic prep();
    int stale;
    mem_rsp_valid = (mq.size() > 0) ? (mq[0].rdy <= cyc) : 1'b0;
    mem_rsp_data = (mq.size() > 0) ? mq[0].data : 32'h0;
    mem_req_ready = (int'($urandom_range(99)) < rdyPct);
    br_taken = brDrv;
    br_pc = bpc;
    br_offset = boff;
    out_ready = ordy;
    #1;
    stale = 0;
    foreach (mq[i]) if (mq[i].ep != epoch) stale++;
    eReqV = !brDrv && ((eq.size() + stale) < DEPTH);
    eOutV = (eq.size() > 0) ? eq[0].full : 1'b0;
    eOutPc = eOutV ? eq[0].pc : 32'h0;
    eOutInstr = eOutV ? eq[0].instr : 32'h0;
  endtask

  // advance the model by one clock using the expected handshakes
  task automatic commit();
    mreq_t m;
    mreq_t n;
    ent_t e;
    bit done;
    int lat;
    if (eOutV && ordy) void'(eq.pop_front());
    if (mem_rsp_valid) begin
      m = mq.pop_front();
      if (!brDrv && m.ep == epoch) begin
        done = 1'b0;
        foreach (eq[i]) begin
          if (!done && !eq[i].full) begin
            eq[i].full = 1'b1;
            eq[i].instr = m.data;
            done = 1'b1;
          end
        end
      end
    end
    if (eReqV && mem_req_ready) begin
      e.pc = nextPc;
      e.instr = 32'h0;
      e.full = 1'b0;
      eq.push_back(e);
      lat = $urandom_range(latMax, latMin);
      n.addr = nextPc;
      n.data = $urandom;
      n.ep = epoch;
      n.rdy = (lastRdy > cyc + lat) ? lastRdy : cyc + lat;
      lastRdy = n.rdy;
      mq.push_back(n);
      nextPc = nextPc + 32'd4;
    end
    if (brDrv) begin
      eq.delete();
      epoch++;
      nextPc = bpc + (boff << 2);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    brDrv = 1'b0;
    ordy = 1'b0;
    br_taken = 1'b0;
    br_pc = '0;
    br_offset = '0;
    out_ready = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    mq.delete();
    eq.delete();
    nextPc = 32'h0;
    epoch++;
    lastRdy = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_stream();
    rdyPct = 100;
    latMin = 1;
    latMax = 1;
    ordy = 1'b1;
    brDrv = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_stream();
    repeat (5) begin
      prep();
      commit();
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errs++;
      $display("FAIL reset_prerun_valid: got %b exp 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_req_valid: got %b exp 0", mem_req_valid);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_out_valid: got %b exp 0", out_valid);
    end
    checks++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errs++;
      $display("FAIL reset_out_data: got %h/%h exp 0/0", out_pc, out_instr);
    end
    do_reset();
    set_stream();
    prep();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
      errs++;
      $display("FAIL reset_first_addr: got v=%b a=%h exp v=1 a=0",
               mem_req_valid, mem_req_addr);
    end
    commit();
  endtask

  task automatic test_stream();
    logic [31:0] got[$];
    int gotCyc[$];
    int startCyc;
    do_reset();
    set_stream();
    startCyc = cyc;
    repeat (10) begin
      prep();
      checks++;
      if (out_valid !== eOutV) begin
        errs++;
        $display("FAIL stream_valid: got %b exp %b", out_valid, eOutV);
      end
      if (eOutV) begin
        checks++;
        if (out_pc !== eOutPc || out_instr !== eOutInstr) begin
          errs++;
          $display("FAIL stream_data: got %h/%h exp %h/%h",
                   out_pc, out_instr, eOutPc, eOutInstr);
        end
      end
      if (out_valid && out_ready) begin
        got.push_back(out_pc);
        gotCyc.push_back(cyc);
      end
      commit();
    end
    checks++;
    if (got.size() < 3) begin
      errs++;
      $display("FAIL stream_count: got %0d exp >=3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== 32'(4 * k)) begin
          errs++;
          $display("FAIL stream_pc%0d: got %h exp %h", k, got[k], 4 * k);
        end
        checks++;
        if (gotCyc[k] != startCyc + 2 + k) begin
          errs++;
          $display("FAIL stream_cycle%0d: got %0d exp %0d",
                   k, gotCyc[k], startCyc + 2 + k);
        end
      end
    end
  endtask

  task automatic test_freeze();
    int issued;
    do_reset();
    set_stream();
    ordy = 1'b0;
    issued = 0;
    repeat (12) begin
      prep();
      if (mem_req_valid && mem_req_ready) issued++;
      checks++;
      if (mem_req_valid !== eReqV) begin
        errs++;
        $display("FAIL freeze_req_valid: got %b exp %b", mem_req_valid, eReqV);
      end
      if (out_valid) begin
        checks++;
        if (out_pc !== 32'h0) begin
          errs++;
          $display("FAIL freeze_hold_pc: got %h exp 0", out_pc);
        end
      end
      commit();
    end
    checks++;
    if (issued != DEPTH) begin
      errs++;
      $display("FAIL freeze_issued: got %0d exp %0d", issued, DEPTH);
    end
    prep();
    checks++;
    if (mem_req_valid !== 1'b0 || out_valid !== 1'b1) begin
      errs++;
      $display("FAIL freeze_final: got req=%b out=%b exp req=0 out=1",
               mem_req_valid, out_valid);
    end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    set_stream();
    latMin = 6;
    latMax = 6;
    for (int k = 0; k < 2; k++) begin
      prep();
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'(4 * k)) begin
        errs++;
        $display("FAIL redir_pre_req%0d: got v=%b a=%h exp v=1 a=%h",
                 k, mem_req_valid, mem_req_addr, 4 * k);
      end
      commit();
    end
    brDrv = 1'b1;
    bpc = 32'h10;
    boff = 32'hFFFF_FFFE;
    prep();
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL redir_no_issue: got %b exp 0", mem_req_valid);
    end
    commit();
    brDrv = 1'b0;
    prep();
    checks++;
    if (mem_req_addr !== 32'h8) begin
      errs++;
      $display("FAIL redir_target: got %h exp 00000008", mem_req_addr);
    end
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      if (t > 0) prep();
      checks++;
      if (mem_req_valid !== eReqV || out_valid !== eOutV) begin
        errs++;
        $display("FAIL redir_flags: got req=%b out=%b exp req=%b out=%b",
                 mem_req_valid, out_valid, eReqV, eOutV);
      end
      if (out_valid) begin
        found = 1'b1;
        checks++;
        if (out_pc !== 32'h8 || out_instr !== eOutInstr) begin
          errs++;
          $display("FAIL redir_first_out: got %h/%h exp 00000008/%h",
                   out_pc, out_instr, eOutInstr);
        end
      end
      commit();
    end
    checks++;
    if (!found) begin
      errs++;
      $display("FAIL redir_timeout: got no out_valid exp one within 30");
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    do_reset();
    set_stream();
    repeat (6) begin
      prep();
      commit();
    end
    brDrv = 1'b1;
    bpc = 32'h100;
    boff = 32'h0;
    prep();
    checks++;
    if (out_valid !== 1'b1 || mem_rsp_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL simul_setup: got out=%b rsp=%b req=%b exp 1/1/0",
               out_valid, mem_rsp_valid, mem_req_valid);
    end
    checks++;
    if (out_pc !== eOutPc) begin
      errs++;
      $display("FAIL simul_pop_pc: got %h exp %h", out_pc, eOutPc);
    end
    commit();
    brDrv = 1'b0;
    prep();
    checks++;
    if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 ||
        mem_req_addr !== 32'h100) begin
      errs++;
      $display("FAIL simul_after: got out=%b req=%b a=%h exp 0/1/00000100",
               out_valid, mem_req_valid, mem_req_addr);
    end
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      if (t > 0) prep();
      if (out_valid) begin
        found = 1'b1;
        checks++;
        if (out_pc !== 32'h100 || out_instr !== eOutInstr) begin
          errs++;
          $display("FAIL simul_first_out: got %h/%h exp 00000100/%h",
                   out_pc, out_instr, eOutInstr);
        end
      end
      commit();
    end
    checks++;
    if (!found) begin
      errs++;
      $display("FAIL simul_timeout: got no out_valid exp one within 10");
    end
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    logic [31:0] tPc [2];
    logic [31:0] tOff [2];
    logic [31:0] tExp [2];
    logic [31:0] seqExp [3];
    tPc[0] = 32'hFFFF_FFF0;
    tOff[0] = 32'h8;
    tExp[0] = 32'h10;
    tPc[1] = 32'h4;
    tOff[1] = 32'hFFFF_FFFC;
    tExp[1] = 32'hFFFF_FFF4;
    seqExp[0] = 32'hFFFF_FFF8;
    seqExp[1] = 32'hFFFF_FFFC;
    seqExp[2] = 32'h0;
    do_reset();
    set_stream();
    brDrv = 1'b1;
    bpc = 32'hFFFF_FFF0;
    boff = 32'h2;
    prep();
    commit();
    brDrv = 1'b0;
    repeat (8) begin
      prep();
      if (eOutV) begin
        checks++;
        if (out_pc !== eOutPc || out_instr !== eOutInstr) begin
          errs++;
          $display("FAIL wrap_data: got %h/%h exp %h/%h",
                   out_pc, out_instr, eOutPc, eOutInstr);
        end
      end
      if (out_valid && out_ready) got.push_back(out_pc);
      commit();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= got.size() || got[k] !== seqExp[k]) begin
        errs++;
        $display("FAIL wrap_seq%0d: got %h exp %h",
                 k, (k < got.size()) ? got[k] : 32'hX, seqExp[k]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      brDrv = 1'b1;
      bpc = tPc[k];
      boff = tOff[k];
      prep();
      commit();
      brDrv = 1'b0;
      prep();
      checks++;
      if (mem_req_addr !== tExp[k]) begin
        errs++;
        $display("FAIL wrap_target%0d: got %h exp %h", k, mem_req_addr, tExp[k]);
      end
      commit();
    end
  endtask

  task automatic test_random();
    int delivered;
    do_reset();
    rdyPct = 70;
    latMin = 1;
    latMax = 4;
    delivered = 0;
    repeat (600) begin
      brDrv = ($urandom_range(19) == 0);
      bpc = $urandom & 32'hFFFF_FFFC;
      boff = $urandom;
      ordy = ($urandom_range(3) != 0);
      prep();
      checks++;
      if (mem_req_valid !== eReqV) begin
        errs++;
        $display("FAIL rand_req_valid: got %b exp %b", mem_req_valid, eReqV);
      end
      if (eReqV) begin
        checks++;
        if (mem_req_addr !== nextPc) begin
          errs++;
          $display("FAIL rand_req_addr: got %h exp %h", mem_req_addr, nextPc);
        end
      end
      checks++;
      if (out_valid !== eOutV) begin
        errs++;
        $display("FAIL rand_out_valid: got %b exp %b", out_valid, eOutV);
      end
      if (eOutV) begin
        checks++;
        if (out_pc !== eOutPc || out_instr !== eOutInstr) begin
          errs++;
          $display("FAIL rand_out_data: got %h/%h exp %h/%h",
                   out_pc, out_instr, eOutPc, eOutInstr);
        end
        if (ordy) delivered++;
      end
      commit();
    end
    checks++;
    if (delivered < 20) begin
      errs++;
      $display("FAIL rand_throughput: got %0d exp >=20", delivered);
    end
  endtask

  initial begin
    rst = 1'b1;
    br_taken = 1'b0;
    br_pc = '0;
    br_offset = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_freeze();
    test_redirect();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
